// File: rtl/bus_sram_responder.sv
// CPU request/ready responder for an asynchronous 16-bit SRAM: two half-word cycles per 32-bit access.
// Define SRAM_READ_BUFFER_EN to add a one-word read buffer that answers repeated reads without an SRAM cycle.
module bus_sram_responder #(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_request,
  input  logic               i_rw,
  input  logic [31:0]        i_address,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_ready,
  output logic [SRAM_AW-1:0] o_sram_a,
  output logic [15:0]        o_sram_d,
  output logic               o_sram_d_oe,
  input  logic [15:0]        i_sram_d,
  output logic               o_sram_ce_n,
  output logic               o_sram_oe_n,
  output logic               o_sram_we_n
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_LO   = 3'd1;
  localparam logic [2:0] S_RD_HI   = 3'd2;
  localparam logic [2:0] S_WR_LO   = 3'd3;
  localparam logic [2:0] S_WR_HI   = 3'd4;
  localparam logic [2:0] S_ACK     = 3'd5;
  localparam logic [2:0] S_RELEASE = 3'd6;

  localparam logic [3:0] WAIT_RELOAD = 4'(WAIT_CYCLES);

  logic [2:0]         state;
  logic [3:0]         wait_cnt;
  logic               wr_recover;
  logic               lat_rw;
  logic [SRAM_AW-2:0] lat_word;
  logic [31:0]        lat_wdata;
  logic [31:0]        rd_data;

  logic [SRAM_AW-2:0] req_word;
  logic               wait_done;
  logic               buf_hit;
  logic [31:0]        buf_data;

  assign req_word  = i_address[SRAM_AW:2];
  assign wait_done = (wait_cnt == 4'd0);

  // Byte-lane bits and bits above the SRAM window do not select anything.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[31:SRAM_AW+1], i_address[1:0]};

`ifdef SRAM_READ_BUFFER_EN
  logic               buf_valid;
  logic [SRAM_AW-2:0] buf_tag;

  assign buf_hit = buf_valid && (buf_tag == req_word);

  // Filled by every completed read; kept coherent by write-through on a tag match.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == S_ACK) begin
      if (!lat_rw) begin
        buf_valid <= 1'b1;
        buf_tag   <= lat_word;
        buf_data  <= rd_data;
      end else if (buf_valid && (buf_tag == lat_word)) begin
        buf_data  <= lat_wdata;
      end
    end
  end
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // Every pad output is a flop loaded with the value for the state being entered,
  // so the asynchronous reset releases the strobes the moment it is asserted.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      wr_recover  <= 1'b0;
      lat_rw      <= 1'b0;
      lat_word    <= '0;
      lat_wdata   <= '0;
      rd_data     <= '0;
      o_rdata     <= '0;
      o_ready     <= 1'b0;
      o_sram_a    <= '0;
      o_sram_d    <= '0;
      o_sram_d_oe <= 1'b0;
      o_sram_ce_n <= 1'b1;
      o_sram_oe_n <= 1'b1;
      o_sram_we_n <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values;
      // blocking ones would let later statements see this edge's updates.
      o_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_request) begin
            lat_rw    <= i_rw;
            lat_word  <= req_word;
            lat_wdata <= i_wdata;
            if (!i_rw && buf_hit) begin
              rd_data <= buf_data;
              state   <= S_ACK;
            end else if (!i_rw) begin
              state       <= S_RD_LO;
              wait_cnt    <= WAIT_RELOAD;
              o_sram_a    <= {req_word, 1'b0};
              o_sram_ce_n <= 1'b0;
              o_sram_oe_n <= 1'b0;
            end else begin
              state       <= S_WR_LO;
              wait_cnt    <= WAIT_RELOAD;
              wr_recover  <= 1'b0;
              o_sram_a    <= {req_word, 1'b0};
              o_sram_d    <= i_wdata[15:0];
              o_sram_d_oe <= 1'b1;
              o_sram_ce_n <= 1'b0;
              o_sram_we_n <= 1'b0;
            end
          end
        end

        S_RD_LO: begin
          if (wait_done) begin
            rd_data[15:0] <= i_sram_d;
            state         <= S_RD_HI;
            wait_cnt      <= WAIT_RELOAD;
            o_sram_a      <= {lat_word, 1'b1};
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_RD_HI: begin
          if (wait_done) begin
            rd_data[31:16] <= i_sram_d;
            state          <= S_ACK;
            o_sram_ce_n    <= 1'b1;
            o_sram_oe_n    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        // Strobe phase, then one recovery cycle with we_n high while address and data hold.
        S_WR_LO: begin
          if (wr_recover) begin
            state       <= S_WR_HI;
            wait_cnt    <= WAIT_RELOAD;
            wr_recover  <= 1'b0;
            o_sram_a    <= {lat_word, 1'b1};
            o_sram_d    <= lat_wdata[31:16];
            o_sram_we_n <= 1'b0;
          end else if (wait_done) begin
            wr_recover  <= 1'b1;
            o_sram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_WR_HI: begin
          if (wr_recover) begin
            state       <= S_ACK;
            wr_recover  <= 1'b0;
            o_sram_d_oe <= 1'b0;
            o_sram_ce_n <= 1'b1;
          end else if (wait_done) begin
            wr_recover  <= 1'b1;
            o_sram_we_n <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_ACK: begin
          o_ready <= 1'b1;
          if (!lat_rw) o_rdata <= rd_data;
          state <= S_RELEASE;
        end

        // The initiator drops request only after seeing ready; wait for that so one request yields one pulse.
        S_RELEASE: begin
          if (!i_request) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
